uart_rx_os: RTL and testbench

//  Parametrised, oversampling UART receiver. Successor to the fixed 8-bit receiver in the UART subsystem.

---
 rtl/uart_rx_os.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os
//  Description : Oversampling UART receiver with 5..DATA_W_MAX data bits,
//                parity/stop options, majority voting, break detection and a
//                valid/ready output register with overrun reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int DATA_W_MAX  = 9,
    parameter int OS_RATE     = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic [DIV_W-1:0]      i_baud_divisor,
    input  logic [3:0]            i_data_bits,
    input  logic [1:0]            i_parity_type,
    input  logic                  i_stop_bits,
    output logic [DATA_W_MAX-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic                  o_framing_error,
    output logic                  o_parity_error,
    output logic                  o_break_detect,
    output logic                  o_overrun_error
);

    localparam int              c_OS_W     = $clog2(OS_RATE);
    localparam logic [c_OS_W-1:0] c_SMP0   = c_OS_W'(OS_RATE/2 - 1);
    localparam logic [c_OS_W-1:0] c_SMP1   = c_OS_W'(OS_RATE/2);
    localparam logic [c_OS_W-1:0] c_SMP2   = c_OS_W'(OS_RATE/2 + 1);
    localparam logic [c_OS_W-1:0] c_DECIDE = c_OS_W'(OS_RATE/2 + 2);
    localparam logic [c_OS_W-1:0] c_LAST   = c_OS_W'(OS_RATE - 1);
    localparam logic [3:0]      c_DW_MAX   = 4'(DATA_W_MAX);
    localparam logic [3:0]      c_DW_MIN   = 4'd5;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_BREAK  = 3'd5;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DIV_W-1:0]       r_presc;
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [c_OS_W-1:0]      r_os_cnt;
    logic [3:0]             r_bit_cnt;
    logic [2:0]             r_smp;
    logic [DATA_W_MAX-1:0]  r_data;
    logic                   r_pbit;
    logic                   r_stop0;
    logic                   r_ferr_acc;
    logic [3:0]             r_nbits;
    logic [1:0]             r_ptype;
    logic                   r_two_stop;

    logic [DATA_W_MAX-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic                   r_ferr;
    logic                   r_perr;
    logic                   r_brk;
    logic                   r_ovr;

    logic                   w_rx;
    logic [DIV_W-1:0]       w_div_eff;
    logic                   w_tick;
    logic                   w_active;
    logic                   w_decide;
    logic                   w_bit_end;
    logic                   w_start_det;
    logic                   w_bit;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic                   w_done;
    logic                   w_first_stop;
    logic                   w_ferr;
    logic                   w_perr;
    logic                   w_brk;
    logic [3:0]             w_nbits_cfg;
    logic [DATA_W_MAX-1:0]  w_data_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
    assign w_rx = r_sync[SYNC_STAGES-1];

    // A divisor of 0 behaves as 1; >= keeps the wrap safe if the divisor shrinks live.
    assign w_div_eff = (i_baud_divisor == '0) ? DIV_W'(1) : i_baud_divisor;
    assign w_tick    = (r_presc >= w_div_eff - DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + DIV_W'(1);
    end

    assign w_active    = (r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                         (r_state == c_ST_PARITY) || (r_state == c_ST_STOP);
    assign w_decide    = w_tick & w_active & (r_os_cnt == c_DECIDE);
    assign w_bit_end   = w_tick & w_active & (r_os_cnt == c_LAST);
    assign w_start_det = (r_state == c_ST_IDLE) & w_tick & ~w_rx;
    assign w_bit       = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
    assign w_last_data = (r_bit_cnt == r_nbits - 4'd1);
    assign w_last_stop = (r_bit_cnt == {3'b000, r_two_stop});
    assign w_done      = (r_state == c_ST_STOP) & w_decide & w_last_stop;

    assign w_first_stop = (r_bit_cnt == 4'd0) ? w_bit : r_stop0;
    assign w_ferr       = r_ferr_acc | ~w_bit;
    assign w_brk        = (r_data == '0) & ((r_ptype == 2'b00) | ~r_pbit) & ~w_first_stop;

    always_comb begin
        w_perr = 1'b0;
        case (r_ptype)
            2'b01:   w_perr = (^r_data) ^ r_pbit;
            2'b10:   w_perr = ~((^r_data) ^ r_pbit);
            2'b11:   w_perr = ~r_pbit;
            default: w_perr = 1'b0;
        endcase
    end

    assign w_nbits_cfg = (i_data_bits < c_DW_MIN) ? c_DW_MIN :
                         (i_data_bits > c_DW_MAX) ? c_DW_MAX : i_data_bits;

    // New bit enters at the top of the active field so the first bit lands at bit 0.
    always_comb begin
        w_data_shift = r_data >> 1;
        for (int i = 0; i < DATA_W_MAX; i++) begin
            if (4'(i) == r_nbits - 4'd1) w_data_shift[i] = w_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_start_det) w_state_nxt = c_ST_START;
            c_ST_START: begin
                if (w_decide && w_bit) w_state_nxt = c_ST_IDLE;
                else if (w_bit_end)    w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_end && w_last_data)
                    w_state_nxt = (r_ptype != 2'b00) ? c_ST_PARITY : c_ST_STOP;
            end
            c_ST_PARITY: if (w_bit_end) w_state_nxt = c_ST_STOP;
            c_ST_STOP:   if (w_done) w_state_nxt = w_brk ? c_ST_BREAK : c_ST_IDLE;
            c_ST_BREAK:  if (w_tick && w_rx) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_smp      <= '1;
            r_data     <= '0;
            r_pbit     <= 1'b0;
            r_stop0    <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_nbits    <= '0;
            r_ptype    <= '0;
            r_two_stop <= 1'b0;
        end else begin
            if (w_start_det) begin
                r_os_cnt   <= '0;
                r_bit_cnt  <= '0;
                r_data     <= '0;
                r_ferr_acc <= 1'b0;
                r_nbits    <= w_nbits_cfg;
                r_ptype    <= i_parity_type;
                r_two_stop <= i_stop_bits;
            end else if (w_tick && w_active) begin
                r_os_cnt <= (r_os_cnt == c_LAST) ? '0 : r_os_cnt + c_OS_W'(1);
                if (r_os_cnt == c_SMP0) r_smp[0] <= w_rx;
                if (r_os_cnt == c_SMP1) r_smp[1] <= w_rx;
                if (r_os_cnt == c_SMP2) r_smp[2] <= w_rx;
            end
            if (w_decide) begin
                case (r_state)
                    c_ST_DATA:   r_data <= w_data_shift;
                    c_ST_PARITY: r_pbit <= w_bit;
                    c_ST_STOP: begin
                        if (!w_bit) r_ferr_acc <= 1'b1;
                        if (r_bit_cnt == 4'd0) r_stop0 <= w_bit;
                    end
                    default: ;
                endcase
            end
            if (w_bit_end) begin
                case (r_state)
                    c_ST_START:  r_bit_cnt <= '0;
                    c_ST_DATA:   r_bit_cnt <= w_last_data ? 4'd0 : r_bit_cnt + 4'd1;
                    c_ST_PARITY: r_bit_cnt <= '0;
                    c_ST_STOP:   r_bit_cnt <= r_bit_cnt + 4'd1;
                    default: ;
                endcase
            end
        end
    end

    // Held word is never overwritten by a frame that arrives before it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_brk      <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_done && (!r_rx_valid || i_rx_ready)) begin
                r_rx_data  <= r_data;
                r_rx_valid <= 1'b1;
                r_ferr     <= w_ferr;
                r_perr     <= w_perr;
                r_brk      <= w_brk;
            end else if (w_done) begin
                r_ovr <= 1'b1;
            end else if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
                r_ferr     <= 1'b0;
                r_perr     <= 1'b0;
                r_brk      <= 1'b0;
            end
        end
    end

    assign o_rx_data       = r_rx_data;
    assign o_rx_valid      = r_rx_valid;
    assign o_framing_error = r_ferr;
    assign o_parity_error  = r_perr;
    assign o_break_detect  = r_brk;
    assign o_overrun_error = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_os
//  Description : Self-checking bench for uart_rx_os: directed frames plus
//                randomized frames checked against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] i_baud_divisor;
    logic [3:0]  i_data_bits;
    logic [1:0]  i_parity_type;
    logic        i_stop_bits;
    logic [8:0]  o_rx_data;
    logic        o_rx_valid;
    logic        rx_ready;
    logic        o_framing_error;
    logic        o_parity_error;
    logic        o_break_detect;
    logic        o_overrun_error;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } frame_t;

    frame_t exp_q[$];
    int     n_vec   = 0;
    int     n_err   = 0;
    int     ovr_cnt = 0;
    int     divv    = 4;
    int     bt      = 64;

    uart_rx_os dut (
        .clk             (clk),
        .rst             (rst),
        .rx              (rx),
        .i_baud_divisor  (i_baud_divisor),
        .i_data_bits     (i_data_bits),
        .i_parity_type   (i_parity_type),
        .i_stop_bits     (i_stop_bits),
        .o_rx_data       (o_rx_data),
        .o_rx_valid      (o_rx_valid),
        .i_rx_ready      (rx_ready),
        .o_framing_error (o_framing_error),
        .o_parity_error  (o_parity_error),
        .o_break_detect  (o_break_detect),
        .o_overrun_error (o_overrun_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted word is compared with the oldest expectation.
    always @(negedge clk) begin
        frame_t e;
        if (o_overrun_error) ovr_cnt++;
        if (!rst && o_rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", 32'(o_rx_data), 32'(e.data));
                check("parity_err", 32'(o_parity_error), 32'(e.perr));
                check("framing_err", 32'(o_framing_error), 32'(e.ferr));
                check("break", 32'(o_break_detect), 32'(e.brk));
            end
        end
    end

    task automatic set_div(input int d);
        divv           = d;
        bt             = ((d == 0) ? 1 : d) * 16;
        i_baud_divisor = 16'(d);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
    endtask

    task automatic push_exp(input logic [8:0] d, input logic pe, input logic fe, input logic bk);
        frame_t f;
        f.data = d; f.perr = pe; f.ferr = fe; f.brk = bk;
        exp_q.push_back(f);
    endtask

    function automatic int clamp_bits(input int nb_raw);
        return (nb_raw < 5) ? 5 : (nb_raw > 9) ? 9 : nb_raw;
    endfunction

    // Frame-level model: expected word and flags from the bits placed on the line.
    task automatic expect_frame(input int nb_raw, input int pt, input int ns, input logic [15:0] data,
                                input logic pbit, input logic s0, input logic s1);
        int          nb;
        int          ones;
        logic [15:0] masked;
        logic        pe;
        nb     = clamp_bits(nb_raw);
        masked = data & ((16'd1 << nb) - 16'd1);
        ones   = $countones(masked);
        case (pt)
            1:       pe = ((ones + int'(pbit)) % 2) == 1;
            2:       pe = ((ones + int'(pbit)) % 2) == 0;
            3:       pe = (pbit == 1'b0);
            default: pe = 1'b0;
        endcase
        push_exp(masked[8:0], pe, !s0 || (ns == 1 && !s1),
                 (masked == 16'd0) && (pt == 0 || !pbit) && !s0);
    endtask

    task automatic send_frame(input int nb_raw, input int pt, input int ns, input logic [15:0] data,
                              input logic pbit, input logic s0, input logic s1, input int spike);
        logic bits[$];
        int   nb;
        int   dv;
        nb = clamp_bits(nb_raw);
        dv = (divv == 0) ? 1 : divv;
        i_data_bits   = 4'(nb_raw);
        i_parity_type = 2'(pt);
        i_stop_bits   = 1'(ns);
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(data[i]);
        if (pt != 0) bits.push_back(pbit);
        bits.push_back(s0);
        if (ns != 0) bits.push_back(s1);
        for (int k = 0; k < bits.size(); k++) begin
            rx = bits[k];
            if (k == spike) begin
                repeat (bt/2) @(negedge clk);
                rx = ~bits[k];
                repeat (dv) @(negedge clk);
                rx = bits[k];
                repeat (bt - bt/2 - dv) @(negedge clk);
            end else begin
                repeat (bt) @(negedge clk);
            end
            if (k == 0) begin
                // Config changes after start must not affect this frame.
                i_data_bits   = 4'($urandom_range(0, 15));
                i_parity_type = 2'($urandom_range(0, 3));
                i_stop_bits   = 1'($urandom_range(0, 1));
            end
        end
        rx = 1'b1;
        repeat (2*bt) @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
        i_data_bits = 4'd8; i_parity_type = 2'd0; i_stop_bits = 1'b0;
        set_div(4);
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(o_rx_valid), 32'd0);
        check("rst_data", 32'(o_rx_data), 32'd0);
        check("rst_flags", 32'({o_framing_error, o_parity_error, o_break_detect}), 32'd0);
        check("rst_ovr", 32'(o_overrun_error), 32'd0);
        rst = 1'b0;
        repeat (bt) @(negedge clk);

        // 8N1 0xA5, held until ready
        push_exp(9'h0A5, 1'b0, 1'b0, 1'b0);
        send_frame(8, 0, 0, 16'h00A5, 1'b0, 1'b1, 1'b0, -1);
        repeat (20) @(negedge clk);
        check("t1_valid_held", 32'(o_rx_valid), 32'd1);
        check("t1_data_held", 32'(o_rx_data), 32'h0A5);
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        check("t1_valid_fall", 32'(o_rx_valid), 32'd0);

        // 7E1 0x3C: pbit=1 is an error, pbit=0 is correct
        push_exp(9'h03C, 1'b1, 1'b0, 1'b0);
        send_frame(7, 1, 0, 16'h003C, 1'b1, 1'b1, 1'b0, -1);
        push_exp(9'h03C, 1'b0, 1'b0, 1'b0);
        send_frame(7, 1, 0, 16'h003C, 1'b0, 1'b1, 1'b0, -1);

        // false start of 3 ticks, then a frame with a 1-tick spike in data bit 2
        i_data_bits = 4'd8; i_parity_type = 2'd0; i_stop_bits = 1'b0;
        rx = 1'b0;
        repeat (3*divv) @(negedge clk);
        rx = 1'b1;
        repeat (2*bt) @(negedge clk);
        check("t3_false_start", 32'(o_rx_valid), 32'd0);
        push_exp(9'h05A, 1'b0, 1'b0, 1'b0);
        send_frame(8, 0, 0, 16'h005A, 1'b0, 1'b1, 1'b0, 3);

        // 9N2 with bad second stop; 5N1 ignores upper data bits
        push_exp(9'h1FF, 1'b0, 1'b1, 1'b0);
        send_frame(9, 0, 1, 16'h01FF, 1'b0, 1'b1, 1'b0, -1);
        push_exp(9'h015, 1'b0, 1'b0, 1'b0);
        send_frame(5, 0, 0, 16'hFFF5, 1'b0, 1'b1, 1'b0, -1);
        drain(200);

        // overrun: second frame dropped while first is held
        set_ready(1'b0);
        begin
            int c0;
            c0 = ovr_cnt;
            push_exp(9'h011, 1'b0, 1'b0, 1'b0);
            send_frame(8, 0, 0, 16'h0011, 1'b0, 1'b1, 1'b0, -1);
            send_frame(8, 0, 0, 16'h0022, 1'b0, 1'b1, 1'b0, -1);
            check("t5_ovr_pulses", 32'(ovr_cnt - c0), 32'd1);
            check("t5_data_kept", 32'(o_rx_data), 32'h011);
            check("t5_valid_kept", 32'(o_rx_valid), 32'd1);
        end
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        push_exp(9'h033, 1'b0, 1'b0, 1'b0);
        send_frame(8, 0, 0, 16'h0033, 1'b0, 1'b1, 1'b0, -1);
        drain(200);

        // break: 12 low bit times, then 4 more with nothing further reported
        i_data_bits = 4'd8; i_parity_type = 2'd0; i_stop_bits = 1'b0;
        push_exp(9'h000, 1'b0, 1'b1, 1'b1);
        rx = 1'b0;
        repeat (12*bt) @(negedge clk);
        check("t6_break_seen", 32'(exp_q.size()), 32'd0);
        repeat (4*bt) @(negedge clk);
        rx = 1'b1;
        repeat (2*bt) @(negedge clk);

        // reset in the middle of the data field
        rx = 1'b0;
        repeat (4*bt) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_rst_valid", 32'(o_rx_valid), 32'd0);
        check("t6_rst_flags", 32'({o_framing_error, o_parity_error, o_break_detect, o_overrun_error}), 32'd0);
        rx = 1'b1;
        rst = 1'b0;
        repeat (2*bt) @(negedge clk);
        push_exp(9'h05A, 1'b0, 1'b0, 1'b0);
        send_frame(8, 0, 0, 16'h005A, 1'b0, 1'b1, 1'b0, -1);
        drain(200);

        // randomized frames against the model
        for (int n = 0; n < 30; n++) begin
            int          nb_raw, pt, ns;
            logic [15:0] d;
            logic        pb, s0, s1;
            set_div($urandom_range(0, 3));
            nb_raw = $urandom_range(0, 15);
            pt     = $urandom_range(0, 3);
            ns     = $urandom_range(0, 1);
            d      = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            pb     = 1'($urandom_range(0, 1));
            s0     = ($urandom_range(0, 4) != 0);
            s1     = ($urandom_range(0, 4) != 0);
            expect_frame(nb_raw, pt, ns, d, pb, s0, s1);
            send_frame(nb_raw, pt, ns, d, pb, s0, s1, -1);
        end
        drain(2000);
        check("ovr_total", 32'(ovr_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
